dense_layer_seq: RTL and testbench

//  Parametrised, time-multiplexed fully-connected neuron layer (N_IN inputs -> N_OUT neurons).

---
 rtl/dense_layer_seq.sv | 174 +++++++++++++++++
 tb/tb_dense_layer_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_layer_seq.sv
// Time-multiplexed fully-connected layer: N_IN inputs -> N_OUT neurons through a single MAC.
// Weights and biases sit in an on-chip register file; vectors move over valid/ready handshakes.
// Optional ReLU activation is enabled by defining DENSE_RELU_EN.
module dense_layer_seq #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned FRAC   = 24,
  parameter int unsigned N_IN   = 2,
  parameter int unsigned N_OUT  = 3,
  parameter int unsigned WADDR  = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      w_we_i,
  input  logic [WADDR-1:0]          w_addr_i,
  input  logic [DWIDTH-1:0]         w_data_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [N_IN*DWIDTH-1:0]    in_vec_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [N_OUT*DWIDTH-1:0]   out_vec_o,
  output logic                      busy_o
);

  localparam int unsigned NWORDS = N_OUT * (N_IN + 1);
  localparam int unsigned NMEM   = 2 ** WADDR;
  localparam int unsigned ACCW   = DWIDTH + 8;
  localparam int unsigned SUMW   = ACCW + 1;
  localparam int unsigned PRODW  = 2 * DWIDTH;
  localparam int unsigned IW     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned JW     = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic signed [SUMW-1:0] SatMax = SUMW'({1'b0, {(DWIDTH-1){1'b1}}});
  localparam logic signed [SUMW-1:0] SatMin = ~SatMax;

  typedef enum logic [1:0] {StIdle, StMac, StBias, StDone} state_e;

  state_e                    state_q, state_d;
  logic signed [DWIDTH-1:0]  wmem_q [NMEM];
  logic signed [DWIDTH-1:0]  x_q    [N_IN];
  logic signed [DWIDTH-1:0]  out_q  [N_OUT];
  logic signed [ACCW-1:0]    acc_q, acc_d;
  logic [IW-1:0]             i_q, i_d;
  logic [JW-1:0]             j_q, j_d;
  // Weight-file read pointer: the layout j*(N_IN+1)+i is walked strictly sequentially,
  // bias included, so a simple incrementing pointer replaces an address multiplier.
  logic [WADDR-1:0]          rp_q, rp_d;

  logic                      accept;
  logic                      w_accept;
  logic                      lane_we;
  logic signed [DWIDTH-1:0]  x_sel;
  logic signed [DWIDTH-1:0]  w_sel;
  logic signed [PRODW-1:0]   prod;
  logic signed [ACCW-1:0]    mac_term;
  logic signed [SUMW-1:0]    sum;
  logic signed [DWIDTH-1:0]  sat_res;
  logic signed [DWIDTH-1:0]  res;

  assign in_ready_o  = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign out_valid_o = (state_q == StDone);

  // Writes only land while idle and inside the populated address range.
  assign w_accept = w_we_i && (state_q == StIdle) && (32'(w_addr_i) < NWORDS);

  // Datapath: operand select, product with floor-shift, bias add, saturation, activation.
  always_comb begin
    x_sel = x_q[0];
    for (int k = 0; k < int'(N_IN); k++) begin
      if (i_q == IW'(k)) x_sel = x_q[k];
    end
    w_sel    = wmem_q[rp_q];
    prod     = x_sel * w_sel;
    mac_term = ACCW'(prod >>> FRAC);
    sum      = SUMW'(acc_q) + SUMW'(w_sel);
    if (sum > SatMax) begin
      sat_res = SatMax[DWIDTH-1:0];
    end else if (sum < SatMin) begin
      sat_res = SatMin[DWIDTH-1:0];
    end else begin
      sat_res = sum[DWIDTH-1:0];
    end
`ifdef DENSE_RELU_EN
    res = sat_res[DWIDTH-1] ? '0 : sat_res;
`else
    res = sat_res;
`endif
  end

  // Next-state logic for the sequencing FSM and its counters.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    rp_d    = rp_q;
    accept  = 1'b0;
    lane_we = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          accept  = 1'b1;
          state_d = StMac;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          rp_d    = '0;
        end
      end
      StMac: begin
        acc_d = acc_q + mac_term;
        rp_d  = rp_q + 1'b1;
        if (i_q == IW'(N_IN - 1)) begin
          state_d = StBias;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      StBias: begin
        lane_we = 1'b1;
        rp_d    = rp_q + 1'b1;
        i_d     = '0;
        acc_d   = '0;
        if (j_q == JW'(N_OUT - 1)) begin
          state_d = StDone;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = StMac;
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters, weight file, latched input and result lanes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      rp_q    <= '0;
      for (int k = 0; k < int'(NMEM); k++) wmem_q[k] <= '0;
      for (int k = 0; k < int'(N_IN); k++) x_q[k] <= '0;
      for (int k = 0; k < int'(N_OUT); k++) out_q[k] <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      rp_q    <= rp_d;
      if (w_accept) wmem_q[w_addr_i] <= w_data_i;
      if (accept) begin
        for (int k = 0; k < int'(N_IN); k++) x_q[k] <= in_vec_i[k*DWIDTH +: DWIDTH];
      end
      if (lane_we) begin
        for (int k = 0; k < int'(N_OUT); k++) begin
          if (j_q == JW'(k)) out_q[k] <= res;
        end
      end
    end
  end

  // Pack result lanes onto the output bus.
  always_comb begin
    out_vec_o = '0;
    for (int k = 0; k < int'(N_OUT); k++) out_vec_o[k*DWIDTH +: DWIDTH] = out_q[k];
  end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Self-checking bench for dense_layer_seq at default parameters (2 inputs, 3 neurons, Q8.24).
module tb_dense_layer_seq;

  localparam int NI = 2;
  localparam int NO = 3;
  localparam int NW = NO * (NI + 1);
  localparam logic [31:0] ONE = 32'h0100_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        w_we_i = 1'b0;
  logic [3:0]  w_addr_i = '0;
  logic [31:0] w_data_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [63:0] in_vec_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [95:0] out_vec_o;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  logic signed [31:0] mw [NW];
  logic [95:0]        exp_q [$];
  int                 cyc = 0;
  int                 acc_cyc = 0;
  logic               prev_valid = 1'b0;

  dense_layer_seq dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .w_we_i      (w_we_i),
    .w_addr_i    (w_addr_i),
    .w_data_i    (w_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_vec_i    (in_vec_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_vec_o   (out_vec_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: sum of floor((x*w)/2^24), plus bias, clipped to 32-bit signed, optional ReLU.
  function automatic logic [95:0] model_vec(input logic [63:0] v);
    logic [95:0] r;
    longint acc;
    longint xv;
    r = '0;
    for (int j = 0; j < NO; j++) begin
      acc = 0;
      for (int i = 0; i < NI; i++) begin
        xv = longint'($signed(v[i*32 +: 32]));
        acc += (xv * longint'(mw[j*(NI+1)+i])) >>> 24;
      end
      acc += longint'(mw[j*(NI+1)+NI]);
      if (acc > 64'sd2147483647) acc = 64'sd2147483647;
      else if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`ifdef DENSE_RELU_EN
      if (acc < 0) acc = 0;
`endif
      r[j*32 +: 32] = acc[31:0];
    end
    return r;
  endfunction

  task automatic write_w(input int addr, input logic [31:0] data);
    @(negedge clk_i);
    w_we_i   = 1'b1;
    w_addr_i = 4'(addr);
    w_data_i = data;
    @(negedge clk_i);
    w_we_i   = 1'b0;
  endtask

  task automatic set_all(input logic [31:0] w, input logic [31:0] b);
    for (int j = 0; j < NO; j++) begin
      write_w(j*3, w);
      write_w(j*3 + 1, w);
      write_w(j*3 + 2, b);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) chk("in_ready timeout", 96'(in_ready_o), 96'd1);
  endtask

  task automatic send_vec(input logic [63:0] v);
    @(negedge clk_i);
    wait_ready();
    in_vec_i   = v;
    in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  task automatic get_res(output logic [95:0] r);
    int n = 0;
    while (!out_valid_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) chk("out_valid timeout", 96'(out_valid_o), 96'd1);
    r = out_vec_o;
    @(negedge clk_i);
  endtask

  initial begin
    logic [95:0] r;
    int seen;
    for (int k = 0; k < NW; k++) mw[k] = '0;

    fork
      // Model: tracks accepted weights and queues expected results per accepted vector.
      forever begin
        @(posedge clk_i or negedge rst_ni);
        if (!rst_ni) begin
          for (int k = 0; k < NW; k++) mw[k] = '0;
          exp_q.delete();
        end else begin
          cyc++;
          if (w_we_i && in_ready_o && int'(w_addr_i) < NW) mw[w_addr_i] = w_data_i;
          if (in_valid_i && in_ready_o) begin
            exp_q.push_back(model_vec(in_vec_i));
            acc_cyc = cyc;
          end
          if (out_valid_o && out_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
      // Compare: every falling edge out of reset.
      forever begin
        @(negedge clk_i);
        if (rst_ni) begin
          chk("in_ready_vs_busy", 96'(in_ready_o), 96'(!busy_o));
          if (out_valid_o) begin
            if (!prev_valid) chk("latency", 96'(cyc - acc_cyc), 96'd9);
            if (exp_q.size() == 0) chk("unexpected out_valid", 96'(out_valid_o), 96'd0);
            else chk("out_vec_model", out_vec_o, exp_q[0]);
          end
          prev_valid = out_valid_o;
        end else begin
          prev_valid = 1'b0;
        end
      end
    join_none

    // Reset state
    #12;
    chk("rst out_valid", 96'(out_valid_o), 96'd0);
    chk("rst busy", 96'(busy_o), 96'd0);
    chk("rst out_vec", out_vec_o, 96'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("in_ready after reset", 96'(in_ready_o), 96'd1);

    // Test 1: unit weights, bias 0.5, inputs {2.0,1.0}
    set_all(ONE, 32'h0080_0000);
    send_vec({32'h0200_0000, ONE});
    get_res(r);
    for (int j = 0; j < NO; j++) chk("t1 lane", 96'(r[j*32 +: 32]), 96'h0380_0000);

    // Test 4: backpressure in DONE, pulsed in_valid ignored
    out_ready_i = 1'b0;
    send_vec({32'h0200_0000, ONE});
    seen = 0;
    while (!out_valid_o && seen < 100) begin
      @(negedge clk_i);
      seen++;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      in_valid_i = (c == 1);
      chk("t4 out_valid held", 96'(out_valid_o), 96'd1);
      chk("t4 out_vec held", out_vec_o, {3{32'h0380_0000}});
      chk("t4 in_ready low", 96'(in_ready_o), 96'd0);
    end
    @(negedge clk_i);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t4 out_valid drop", 96'(out_valid_o), 96'd0);
    chk("t4 in_ready back", 96'(in_ready_o), 96'd1);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (out_valid_o || busy_o) seen++;
    end
    chk("t4 pulse not accepted", 96'(seen), 96'd0);

    // Test 5: write while busy dropped; write in idle used; same-cycle write+accept
    send_vec({32'h0200_0000, ONE});
    w_we_i = 1'b1; w_addr_i = 4'd0; w_data_i = 32'h0200_0000;
    @(negedge clk_i);
    w_we_i = 1'b0;
    get_res(r);
    chk("t5 busy write dropped", 96'(r[31:0]), 96'h0380_0000);
    write_w(0, 32'h0200_0000);
    send_vec({32'h0200_0000, ONE});
    get_res(r);
    chk("t5 idle write used", 96'(r[31:0]), 96'h0480_0000);
    @(negedge clk_i);
    wait_ready();
    w_we_i = 1'b1; w_addr_i = 4'd3; w_data_i = 32'h0200_0000;
    in_vec_i = {32'h0200_0000, ONE}; in_valid_i = 1'b1;
    @(negedge clk_i);
    w_we_i = 1'b0; in_valid_i = 1'b0;
    get_res(r);
    chk("t5 same-cycle write", 96'(r[63:32]), 96'h0480_0000);
    write_w(0, ONE);
    write_w(3, ONE);

    // Test 2: neuron 0 weights -1.0, bias 0
    write_w(0, 32'hFF00_0000);
    write_w(1, 32'hFF00_0000);
    write_w(2, 32'h0);
    send_vec({ONE, ONE});
    get_res(r);
`ifdef DENSE_RELU_EN
    chk("t2 lane0", 96'(r[31:0]), 96'h0);
`else
    chk("t2 lane0", 96'(r[31:0]), 96'hFE00_0000);
`endif
    chk("t2 lane1", 96'(r[63:32]), 96'h0280_0000);

    // Test 3: saturation both directions
    set_all(32'h6400_0000, 32'h0);
    send_vec({32'h6400_0000, 32'h6400_0000});
    get_res(r);
    chk("t3 pos sat", r, {3{32'h7FFF_FFFF}});
    set_all(32'h9C00_0000, 32'h0);
    send_vec({32'h6400_0000, 32'h6400_0000});
    get_res(r);
`ifdef DENSE_RELU_EN
    chk("t3 neg sat", r, 96'h0);
`else
    chk("t3 neg sat", r, {3{32'h8000_0000}});
`endif

    // Test 6: reset during MAC aborts and clears weights
    set_all(ONE, 32'h0080_0000);
    send_vec({32'h0200_0000, ONE});
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6 out_valid", 96'(out_valid_o), 96'd0);
    chk("t6 out_vec", out_vec_o, 96'd0);
    chk("t6 busy", 96'(busy_o), 96'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    send_vec({32'h0200_0000, ONE});
    get_res(r);
    chk("t6 cleared weights", r, 96'd0);

    repeat (3) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
